player_shot_ctl: RTL and testbench

//  Player projectile controller, downstream of the player movement block: consumes

---
 rtl/player_shot_ctl_if.sv | 23 ++
 rtl/player_shot_ctl.sv | 121 ++++++++++++
 tb/tb_player_shot_ctl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/player_shot_ctl_if.sv
// Player shot controller bus.
// Groups the fire/position/hit inputs and the shot state outputs.
//   master : drives button_fire, player_xpos, hit; observes shot_* (upstream/bench side)
//   slave  : the shot controller itself
interface player_shot_ctl_if;
    logic        button_fire;  // debounced fire button, level
    logic [11:0] player_xpos;  // current player x (px)
    logic        hit;          // 1-cycle pulse from collision stage
    logic        shot_active;  // shot on screen
    logic [11:0] shot_xpos;    // shot left x (px)
    logic [11:0] shot_ypos;    // shot top y (px)
    logic        shot_fired;   // 1-cycle launch pulse

    modport master (
        output button_fire, player_xpos, hit,
        input  shot_active, shot_xpos, shot_ypos, shot_fired
    );

    modport slave (
        input  button_fire, player_xpos, hit,
        output shot_active, shot_xpos, shot_ypos, shot_fired
    );
endinterface

// File: rtl/player_shot_ctl.sv
// Player projectile controller.
// Launches a single shot from the ship centre on a fire-button rising edge,
// moves it up SHOT_SPEED px on each slow movement tick, and retires it on a
// collision hit or when it would leave the top of the screen. After a shot
// ends, a cooldown of COOLDOWN_TICKS ticks must elapse before the next launch.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : player_shot_ctl_if.slave (fire/xpos/hit in, shot state out)
module player_shot_ctl #(
    parameter int PLAYER_WIDTH   = 32,
    parameter int PLAYER_YPOS    = 700,
    parameter int SHOT_HEIGHT    = 16,
    parameter int SHOT_SPEED     = 8,
    parameter int SHOT_DELAY     = 650000,
    parameter int COOLDOWN_TICKS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    player_shot_ctl_if.slave     bus
);

    localparam logic [11:0] X_OFS   = 12'(PLAYER_WIDTH / 2);
    localparam logic [11:0] Y_START = 12'(PLAYER_YPOS - SHOT_HEIGHT);
    localparam logic [11:0] Y_STEP  = 12'(SHOT_SPEED);
    localparam logic [31:0] DELAY   = 32'(SHOT_DELAY);
    localparam logic [31:0] CD_MAX  = 32'(COOLDOWN_TICKS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] tick_cnt;
    logic [31:0] cd_cnt;
    logic        tick;
    logic        fire_prev;
    logic        rise;

    logic        active_q;
    logic [11:0] xpos_q;
    logic [11:0] ypos_q;
    logic        fired_q;

    assign rise = bus.button_fire & ~fire_prev;

    assign bus.shot_active = active_q;
    assign bus.shot_xpos   = xpos_q;
    assign bus.shot_ypos   = ypos_q;
    assign bus.shot_fired  = fired_q;

    // Free-running movement tick: one-cycle pulse every SHOT_DELAY+1 clocks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == DELAY) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
            tick     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cd_cnt    <= '0;
            active_q  <= 1'b0;
            xpos_q    <= '0;
            ypos_q    <= '0;
            fired_q   <= 1'b0;
            // Preset high so a button held through reset is not seen as an edge.
            fire_prev <= 1'b1;
        end else begin
            fire_prev <= bus.button_fire;
            fired_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= FLYING;
                        active_q <= 1'b1;
                        fired_q  <= 1'b1;
                        xpos_q   <= bus.player_xpos + X_OFS;  // wraps mod 4096
                        ypos_q   <= Y_START;
                    end
                end
                FLYING: begin
                    // x is frozen at launch; hit takes priority over movement.
                    if (bus.hit) begin
                        state    <= COOLDOWN;
                        active_q <= 1'b0;
                        cd_cnt   <= '0;
                    end else if (tick && (ypos_q < Y_STEP)) begin
                        // Next step would underflow past the top row.
                        state    <= COOLDOWN;
                        active_q <= 1'b0;
                        cd_cnt   <= '0;
                    end else if (tick) begin
                        ypos_q <= ypos_q - Y_STEP;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == CD_MAX) begin
                        state <= IDLE;
                    end else if (tick) begin
                        cd_cnt <= cd_cnt + 32'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_shot_ctl.sv
// Directed self-checking bench for player_shot_ctl (SHOT_DELAY=3, COOLDOWN_TICKS=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, after the edge's register updates have settled.
module tb_player_shot_ctl;

    logic clk;
    logic rst;
    int   ncmp;
    int   nerr;

    player_shot_ctl_if bus ();

    player_shot_ctl #(
        .SHOT_DELAY     (3),
        .COOLDOWN_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step until shot_ypos equals tgt or the cycle budget runs out, then compare.
    task automatic wait_y(input logic [11:0] tgt, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (bus.shot_ypos == tgt) break;
            step();
        end
        chk(tag, 32'(bus.shot_ypos), 32'(tgt));
    endtask

    task automatic wait_act(input logic v, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (bus.shot_active == v) break;
            step();
        end
        chk(tag, 32'(bus.shot_active), 32'(v));
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rst = 1'b0;
        bus.button_fire = 1'b1;
        bus.player_xpos = 12'd512;
        bus.hit = 1'b0;

        // 1: reset state, button held through reset must not fire
        step(); step(); step();
        chk("rst_active", 32'(bus.shot_active), 0);
        chk("rst_xpos",   32'(bus.shot_xpos),   0);
        chk("rst_ypos",   32'(bus.shot_ypos),   0);
        chk("rst_fired",  32'(bus.shot_fired),  0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("held_active", 32'(bus.shot_active), 0);
            chk("held_fired",  32'(bus.shot_fired),  0);
        end

        // 2: launch from xpos 512
        bus.button_fire = 1'b0;
        step();
        bus.button_fire = 1'b1;
        step();
        chk("l1_active", 32'(bus.shot_active), 1);
        chk("l1_xpos",   32'(bus.shot_xpos),   528);
        chk("l1_ypos",   32'(bus.shot_ypos),   684);
        chk("l1_fired",  32'(bus.shot_fired),  1);
        step();
        chk("l1_fired_drop", 32'(bus.shot_fired), 0);
        wait_y(12'd676, 8, "tick1_ypos");
        wait_y(12'd668, 8, "tick2_ypos");
        wait_y(12'd660, 8, "tick3_ypos");
        chk("fly_xpos", 32'(bus.shot_xpos), 528);

        // 3: top exit, cooldown ignores fire, relaunch afterwards
        wait_y(12'd4, 400, "reach_y4");
        wait_act(1'b0, 8, "top_exit_active");
        chk("top_exit_ypos_hold", 32'(bus.shot_ypos), 4);
        bus.button_fire = 1'b0;
        step();
        bus.button_fire = 1'b1;
        step();
        chk("cd_fire_active", 32'(bus.shot_active), 0);
        chk("cd_fire_fired",  32'(bus.shot_fired),  0);
        step();
        chk("cd_fire_late",   32'(bus.shot_active), 0);
        bus.button_fire = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("cd_over_idle", 32'(bus.shot_active), 0);
        bus.button_fire = 1'b1;
        step();
        chk("l2_active", 32'(bus.shot_active), 1);
        chk("l2_fired",  32'(bus.shot_fired),  1);
        chk("l2_ypos",   32'(bus.shot_ypos),   684);

        // 4: hit coincident with a tick at ypos 300; hit wins
        // y changes on the edge after each tick, so the next tick-sampling
        // edge is 4 edges after the observed change.
        wait_y(12'd300, 300, "reach_y300");
        step(); step(); step();
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        chk("hit_active", 32'(bus.shot_active), 0);
        chk("hit_ypos",   32'(bus.shot_ypos),   300);
        for (int i = 0; i < 12; i++) step();
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        chk("idle_hit_ignored", 32'(bus.shot_active), 0);

        // 5: relaunch attempt and player motion during flight
        bus.button_fire = 1'b0;
        bus.player_xpos = 12'd100;
        step();
        bus.button_fire = 1'b1;
        step();
        chk("l3_xpos",  32'(bus.shot_xpos),  116);
        chk("l3_fired", 32'(bus.shot_fired), 1);
        bus.button_fire = 1'b0;
        step();
        bus.button_fire = 1'b1;
        bus.player_xpos = 12'd900;
        step();
        chk("refire_fired",  32'(bus.shot_fired),  0);
        chk("refire_xpos",   32'(bus.shot_xpos),   116);
        step(); step();
        chk("refire_active", 32'(bus.shot_active), 1);
        chk("drag_xpos",     32'(bus.shot_xpos),   116);

        // 6: reset mid-flight
        wait_y(12'd404, 200, "reach_y404");
        rst = 1'b0;
        step();
        chk("midrst_active", 32'(bus.shot_active), 0);
        chk("midrst_xpos",   32'(bus.shot_xpos),   0);
        chk("midrst_ypos",   32'(bus.shot_ypos),   0);
        chk("midrst_fired",  32'(bus.shot_fired),  0);
        rst = 1'b1;
        step(); step();
        chk("post_rst_idle", 32'(bus.shot_active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
